// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator: mode encoding, decimation
// limits and the prime counter width.
package cic_pkg;

  // Conversion mode as seen on the mode input.
  typedef enum logic {
    MODE_INCR = 1'b0,  // integrate-and-dump, no comb section
    MODE_CONT = 1'b1   // full CIC with comb section
  } mode_e;

  // Smallest usable decimation factor; requests of 0 or 1 are raised to it.
  localparam int unsigned MIN_DEC = 2;

  // Width of the counter that tracks comb priming frames (ORDER <= 4).
  localparam int unsigned PRIME_W = 3;

  // Raise a requested decimation factor to the smallest usable value.
  function automatic int unsigned clamp_dec(input int unsigned m);
    return (m < MIN_DEC) ? MIN_DEC : m;
  endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Bundle of the CIC decimator's stream input, control inputs and the
// valid/ready result port. The decimator is the slave; whoever feeds
// modulator bits and consumes results is the master.
interface cic_decimator_if #(
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
);

  logic             x_in;
  logic             x_valid;
  logic             mode;
  logic [CNT_W-1:0] dec_m;
  logic             clear;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  modport master (
    output x_in, x_valid, mode, dec_m, clear, out_ready,
    input  out_data, out_valid, overrun
  );

  modport slave (
    input  x_in, x_valid, mode, dec_m, clear, out_ready,
    output out_data, out_valid, overrun
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One differentiator of the CIC comb section: o_data = i_data - delayed
// i_data, where the delay advances only at the decimated rate (i_en).
module cic_comb_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_dly;

  // Subtraction wraps modulo 2^W, which is what makes CIC wrap-safe.
  assign o_data = i_data - r_dly;

  // Unit delay at the decimated rate, flushed by a synchronous clear.
  // NOTE: state is updated with <= so every stage samples the value its
  // predecessor held before the edge; blocking = would ripple the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly <= '0;
    end else if (i_clr) begin
      r_dly <= '0;
    end else if (i_en) begin
      r_dly <= i_data;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator for a 1-bit delta-sigma stream. Incremental mode dumps the
// last integrator at each frame end; continuous mode runs the full CIC with
// a comb chain at the decimated rate. Results leave through a single-entry
// valid/ready register with sticky overrun. OUT_W/CNT_W must match the
// parameters of the connected interface instance. ORDER is legal in 1..4.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int ORDER = 2,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  cic_decimator_if.slave bus
);

  // Integrator cascade state and its next value on an accepted sample.
  logic [OUT_W-1:0]   r_integ     [ORDER];
  logic [OUT_W-1:0]   w_integ_nxt [ORDER];

  // Framing: sample counter, latched decimation factor, priming progress.
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_mq;
  logic [PRIME_W-1:0] r_prime;
  mode_e              r_mode;

  // Output register.
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_overrun;

  // Comb chain taps: w_comb[0] is the dump value, w_comb[ORDER] the result.
  logic [OUT_W-1:0]   w_comb [ORDER+1];

  logic               w_mode_chg;
  logic               w_flush;
  logic               w_accept;
  logic               w_frame_end;
  logic               w_cont;
  logic               w_primed;
  logic               w_load;
  logic [CNT_W-1:0]   w_mq_in;
  logic [OUT_W-1:0]   w_sum;
  logic [OUT_W-1:0]   w_result;

  // A mode change restarts conversion exactly like clear; the sample
  // presented on that edge is discarded along with everything else.
  assign w_mode_chg  = (mode_e'(bus.mode) != r_mode);
  assign w_flush     = bus.clear | w_mode_chg;
  assign w_accept    = bus.x_valid & ~w_flush;
  assign w_cont      = (r_mode == MODE_CONT);

  // Decimation factor as it would be latched at the start of a frame.
  assign w_mq_in     = CNT_W'(clamp_dec(32'(bus.dec_m)));

  // Mq is at least 2, so a frame can never end on the sample with count 0.
  assign w_frame_end = w_accept && (r_cnt != '0) &&
                       (r_cnt == r_mq - CNT_W'(1));

  // Continuous mode emits only after every comb delay holds a real sample.
  assign w_primed    = (r_prime == PRIME_W'(ORDER));
  assign w_load      = w_frame_end && (!w_cont || w_primed);

  // Registered integrator cascade: each stage adds the old value of its
  // predecessor, so the current sample reaches stage k after k edges.
  // NOTE: always_comb assigns every element unconditionally, so no latch
  // can be inferred for the next-state array.
  always_comb begin
    w_integ_nxt[0] = r_integ[0] + OUT_W'(bus.x_in);
    for (int k = 1; k < ORDER; k++) begin
      w_integ_nxt[k] = r_integ[k] + r_integ[k-1];
    end
  end

  // Value the last integrator takes on this edge, current sample included.
  assign w_sum     = w_integ_nxt[ORDER-1];
  assign w_comb[0] = w_sum;

  // Integrators accumulate accepted samples; incremental mode dumps them
  // to zero at each frame end, continuous mode lets them wrap freely.
  // NOTE: the integrators are a small flop array, not RAM, so every entry
  // takes the async reset; an X left here would never wash out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
    end else if (w_flush || (w_frame_end && !w_cont)) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= w_integ_nxt[k];
    end
  end

  // Framing control: sample counter, Mq latch at frame start, prime count
  // and the registered mode copy used for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mq    <= '0;
      r_prime <= '0;
      r_mode  <= MODE_INCR;
    end else begin
      r_mode <= mode_e'(bus.mode);
      if (w_flush) begin
        r_cnt   <= '0;
        r_prime <= '0;
        r_mq    <= w_mq_in;
      end else if (w_accept) begin
        if (r_cnt == '0) begin
          r_mq <= w_mq_in;
        end
        r_cnt <= w_frame_end ? '0 : r_cnt + CNT_W'(1);
        if (w_frame_end && w_cont && !w_primed) begin
          r_prime <= r_prime + PRIME_W'(1);
        end
      end
    end
  end

  // Comb section: ORDER differentiators clocked at the decimated rate.
  // They are only enabled in continuous mode and are flushed on any
  // restart, so in incremental mode their delays sit at zero.
  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    cic_comb_stage #(
      .W (OUT_W)
    ) u_comb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_frame_end && w_cont),
      .i_clr  (w_flush),
      .i_data (w_comb[g]),
      .o_data (w_comb[g+1])
    );
  end

  assign w_result = w_cont ? w_comb[ORDER] : w_sum;

  // Single-entry result buffer: a new result always wins, overwriting an
  // unconsumed one sets the sticky overrun; a restart drops the pending
  // result but leaves the last data visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_flush) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_result;
      r_out_valid <= 1'b1;
      if (r_out_valid && !bus.out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: one ORDER=1 and one ORDER=2 instance
// share control inputs; x_valid is steered to one of them at a time.
// Expected results are queued when the frame-ending sample is driven and
// popped by a monitor whenever a result is handed over (valid && ready).
module tb_cic_decimator;

  localparam int OUT_W = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cic_decimator_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus1 ();
  cic_decimator_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus2 ();

  cic_decimator #(.ORDER(1), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  cic_decimator #(.ORDER(2), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // Shared stimulus; sel chooses which instance sees x_valid.
  logic             s_x;
  logic             s_xv;
  logic             s_mode;
  logic             s_clear;
  logic             s_ready;
  logic [CNT_W-1:0] s_dec;
  int               sel;

  assign bus1.x_in      = s_x;
  assign bus1.x_valid   = s_xv && (sel == 1);
  assign bus1.mode      = s_mode;
  assign bus1.dec_m     = s_dec;
  assign bus1.clear     = s_clear;
  assign bus1.out_ready = s_ready;

  assign bus2.x_in      = s_x;
  assign bus2.x_valid   = s_xv && (sel == 2);
  assign bus2.mode      = s_mode;
  assign bus2.dec_m     = s_dec;
  assign bus2.clear     = s_clear;
  assign bus2.out_ready = s_ready;

  logic [OUT_W-1:0] q1 [$];
  logic [OUT_W-1:0] q2 [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One all-ones frame of m samples on the selected instance; optionally
  // queue the result the frame-ending sample should produce.
  task automatic frame(input int m, input bit push, input logic [OUT_W-1:0] exp);
    s_x  = 1'b1;
    s_xv = 1'b1;
    repeat (m - 1) step();
    if (push) begin
      if (sel == 1) q1.push_back(exp);
      else          q2.push_back(exp);
    end
    step();
    s_xv = 1'b0;
  endtask

  // Monitor: every handover must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut1 unexpected result: got %0d, expected none", bus1.out_data);
      end else begin
        check("dut1 result", 32'(bus1.out_data), 32'(q1.pop_front()));
      end
    end
    if (rst_n === 1'b1 && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut2 unexpected result: got %0d, expected none", bus2.out_data);
      end else begin
        check("dut2 result", 32'(bus2.out_data), 32'(q2.pop_front()));
      end
    end
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel     = 0;
    s_x     = 1'b0;
    s_xv    = 1'b0;
    s_mode  = 1'b0;
    s_clear = 1'b0;
    s_ready = 1'b1;
    s_dec   = 8'd16;
    rst_n   = 1'b0;

    // Reset state.
    #12;
    check("reset out_valid", 32'(bus1.out_valid), 0);
    check("reset out_data", 32'(bus1.out_data), 0);
    check("reset overrun", 32'(bus1.overrun), 0);
    check("reset out_valid o2", 32'(bus2.out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ORDER=1, incremental, M=16, all ones: 16 per frame, 16-edge latency.
    sel  = 1;
    s_x  = 1'b1;
    s_xv = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      if (i % 16 == 0) q1.push_back(16'd16);
      step();
      if (i == 15) check("o1 no valid before frame end", 32'(bus1.out_valid), 0);
      if (i == 16) check("o1 valid after first frame", 32'(bus1.out_valid), 1);
    end
    s_xv = 1'b0;
    step();
    check("o1 overrun with ready high", 32'(bus1.overrun), 0);
    check("o1 all results seen", 32'(q1.size()), 0);

    // ORDER=2, incremental, M=16: all ones gives 120, alternating gives 64.
    sel = 2;
    frame(16, 1'b1, 16'd120);
    frame(16, 1'b1, 16'd120);
    s_xv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_x = (i % 2 == 0);
      if (i == 15) q2.push_back(16'd64);
      step();
    end
    s_xv = 1'b0;
    step();
    check("o2 incremental results seen", 32'(q2.size()), 0);

    // ORDER=2, continuous, M=16: two priming frames, then 256 every frame,
    // also after the second integrator wraps (400 samples > 362).
    s_mode = 1'b1;
    step();
    for (int f = 1; f <= 25; f++) begin
      frame(16, (f >= 3), 16'd256);
      if (f == 2) check("o2 no result while priming", 32'(bus2.out_valid), 0);
      if (f == 3) check("o2 first continuous result", 32'(bus2.out_data), 256);
    end
    step();
    check("o2 continuous results seen", 32'(q2.size()), 0);
    check("o2 continuous overrun", 32'(bus2.overrun), 0);

    // ORDER=1, incremental, M=4 with the consumer stalled.
    sel     = 1;
    s_mode  = 1'b0;
    s_dec   = 8'd4;
    s_ready = 1'b0;
    step();
    frame(4, 1'b0, '0);
    check("stall 1st valid", 32'(bus1.out_valid), 1);
    check("stall 1st data", 32'(bus1.out_data), 4);
    check("stall 1st overrun", 32'(bus1.overrun), 0);
    frame(4, 1'b0, '0);
    check("stall 2nd valid", 32'(bus1.out_valid), 1);
    check("stall 2nd overrun", 32'(bus1.overrun), 1);
    frame(4, 1'b0, '0);
    check("stall 3rd data", 32'(bus1.out_data), 4);
    check("stall 3rd overrun", 32'(bus1.overrun), 1);
    q1.push_back(16'd4);
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    check("drain valid", 32'(bus1.out_valid), 0);
    check("drain overrun sticky", 32'(bus1.overrun), 1);

    // clear releases overrun; dec_m change mid-frame waits for next frame.
    s_ready = 1'b1;
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    check("clear overrun", 32'(bus1.overrun), 0);
    check("clear holds data", 32'(bus1.out_data), 4);
    s_dec = 8'd16;
    s_x   = 1'b1;
    s_xv  = 1'b1;
    repeat (5) step();
    s_dec = 8'd8;
    repeat (10) step();
    q1.push_back(16'd16);
    step();
    repeat (7) step();
    q1.push_back(16'd8);
    step();
    s_dec = 8'd1;
    step();
    q1.push_back(16'd2);
    step();
    s_xv = 1'b0;
    step();
    check("dec_m change results seen", 32'(q1.size()), 0);

    // clear mid-frame with a result pending.
    s_dec   = 8'd4;
    s_ready = 1'b0;
    frame(4, 1'b0, '0);
    check("pre-clear valid", 32'(bus1.out_valid), 1);
    s_xv = 1'b1;
    repeat (2) step();
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    check("clear drops valid", 32'(bus1.out_valid), 0);
    check("clear keeps data", 32'(bus1.out_data), 4);
    s_ready = 1'b1;
    repeat (3) step();
    check("clear restarts count", 32'(bus1.out_valid), 0);
    q1.push_back(16'd4);
    step();
    s_xv = 1'b0;
    step();

    // Mode toggle mid-frame with a result pending and overrun set.
    s_ready = 1'b0;
    frame(4, 1'b0, '0);
    frame(4, 1'b0, '0);
    check("pre-toggle overrun", 32'(bus1.overrun), 1);
    s_xv = 1'b1;
    step();
    s_mode = 1'b1;
    step();
    check("toggle drops valid", 32'(bus1.out_valid), 0);
    check("toggle clears overrun", 32'(bus1.overrun), 0);
    s_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) q1.push_back(16'd4);
      step();
    end
    s_xv = 1'b0;
    step();
    check("toggle results seen", 32'(q1.size()), 0);

    // Asynchronous reset in the middle of a cycle.
    s_mode  = 1'b0;
    s_ready = 1'b0;
    step();
    frame(4, 1'b0, '0);
    frame(4, 1'b0, '0);
    check("pre-reset overrun", 32'(bus1.overrun), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset out_data", 32'(bus1.out_data), 0);
    check("async reset out_valid", 32'(bus1.out_valid), 0);
    check("async reset overrun", 32'(bus1.overrun), 0);
    step();
    rst_n = 1'b1;
    step();
    check("final queue o2", 32'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
